rsa_mmio_ctrl: RTL and testbench

Parametrised register bank and sequencing controller for the RSA modular-exponentiation datapath. It sits between the SPI register slave (byte-wide register bus) and an `OP_W`-bit RSA core. It maps multi-byte operands and the result into the byte address space and snapshots operands at start. It sequences core reset/enable with a watchdog timeout, and reports status, errors and an interrupt.

---
 rtl/rsa_mmio_ctrl.sv | 111 +++++++++++
 tb/tb_rsa_mmio_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rsa_mmio_ctrl.sv
// rsa_mmio_ctrl: byte-wide register bank and run sequencer for the RSA modexp core
module rsa_mmio_ctrl #(
   parameter int REG_W     = 8,
   parameter int OP_W      = 16,
   parameter int ADDR_W    = 4,
   parameter int TIMEOUT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [REG_W-1:0]  reg_wdata,
   input  logic              reg_we,
   output logic [REG_W-1:0]  reg_rdata,
   input  logic              start_pin,
   output logic              core_en,
   output logic              core_rstb,
   output logic [OP_W-1:0]   core_p,
   output logic [OP_W-1:0]   core_e,
   output logic [OP_W-1:0]   core_m,
   output logic [OP_W-1:0]   core_const,
   input  logic              core_eoc,
   input  logic [OP_W-1:0]   core_c,
   output logic              irq
);
   localparam int NB = OP_W / REG_W;
   localparam int NO = 4 * NB;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [REG_W-1:0] bank [NO];
   logic [NO*REG_W-1:0] bank_flat;
   logic [OP_W-1:0] c_reg;
   logic [TIMEOUT_W-1:0] wdog;
   logic [2:0] pin_q;
   logic irq_f, done_f, err_to, err_wb, aborted, irq_en;
   logic wr_ctl, start_cmd, stop_cmd, clr_cmd, op_wr, busy, wd_end, load_en;
   genvar b;
   for (b = 0; b < NO; b++) begin : g_flat
      assign bank_flat[b*REG_W +: REG_W] = bank[b];
   end
   assign wr_ctl    = reg_we && reg_addr == ADDR_W'(1);
   assign stop_cmd  = wr_ctl && reg_wdata[1];
   assign start_cmd = ((wr_ctl && reg_wdata[0]) || (pin_q[1] && !pin_q[2])) && !stop_cmd;
   assign clr_cmd   = wr_ctl && reg_wdata[2];
   assign op_wr     = reg_we && reg_addr >= ADDR_W'(2) && reg_addr < ADDR_W'(2 + NO);
   assign busy      = state == LOAD || state == RUN;
   assign wd_end    = wdog == ~TIMEOUT_W'(1);
   assign load_en   = state_nx == LOAD;
   assign irq       = irq_f;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   // next state and core handshake outputs; eoc outranks stop, stop outranks watchdog
   always_comb begin
      state_nx  = state;
      core_en   = state == RUN;
      core_rstb = state == RUN || state == DONE;
      case (state)
         IDLE:    state_nx = start_cmd ? LOAD : IDLE;
         LOAD:    state_nx = stop_cmd ? IDLE : RUN;
         RUN:     state_nx = core_eoc ? DONE : (stop_cmd || wd_end) ? IDLE : RUN;
         DONE:    state_nx = stop_cmd ? IDLE : start_cmd ? LOAD : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // start_pin two-flop synchroniser plus edge-detect register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pin_q <= '0;
      else        pin_q <= {pin_q[1:0], start_pin};
   // operand bank, writable at any time
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < NO; i++) bank[i] <= '0;
      else        for (int i = 0; i < NO; i++) if (reg_we && reg_addr == ADDR_W'(2 + i)) bank[i] <= reg_wdata;
   // operand snapshot on LOAD entry, watchdog, result capture
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {core_p, core_e, core_m, core_const, c_reg} <= '0;
         wdog <= '0;
      end else begin
         if (load_en) {core_const, core_m, core_e, core_p} <= bank_flat;
         wdog <= load_en ? '0 : state == RUN ? wdog + TIMEOUT_W'(1) : wdog;
         if (state == RUN && core_eoc) c_reg <= core_c;
      end
   // status flags: clears first so a same-cycle set event wins
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {irq_f, done_f, err_to, err_wb, aborted, irq_en} <= '0;
      end else begin
         if (clr_cmd) {irq_f, err_to, err_wb, aborted} <= '0;
         if (load_en) {irq_f, done_f, err_to, aborted} <= '0;
         if (state == RUN && core_eoc) begin
            done_f <= 1'b1;
            if (irq_en) irq_f <= 1'b1;
         end else if (state == RUN && stop_cmd) begin
            aborted <= 1'b1;
         end else if (state == RUN && wd_end) begin
            err_to <= 1'b1;
            if (irq_en) irq_f <= 1'b1;
         end
         if (op_wr && busy) err_wb <= 1'b1;
         if (wr_ctl) irq_en <= reg_wdata[3];
      end
   // combinational register read mux; unmapped addresses read zero
   always_comb begin
      reg_rdata = '0;
      if (reg_addr == ADDR_W'(0)) reg_rdata = REG_W'({aborted, err_wb, err_to, busy, done_f, irq_f});
      if (reg_addr == ADDR_W'(1)) reg_rdata = REG_W'({irq_en, 3'b000});
      for (int i = 0; i < NO; i++) if (reg_addr == ADDR_W'(2 + i)) reg_rdata = bank[i];
      for (int i = 0; i < NB; i++) if (reg_addr == ADDR_W'(2 + NO + i)) reg_rdata = c_reg[i*REG_W +: REG_W];
   end
endmodule

// File: tb/tb_rsa_mmio_ctrl.sv
// tb_rsa_mmio_ctrl: directed register-level test with a queued scoreboard
module tb_rsa_mmio_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] reg_addr = '0;
   logic [7:0] reg_wdata = '0, reg_rdata;
   logic reg_we = 1'b0, start_pin = 1'b0, core_eoc = 1'b0;
   logic core_en, core_rstb, irq;
   logic [15:0] core_p, core_e, core_m, core_const, core_c = '0;
   typedef struct {
      string       name;
      logic [31:0] mask;
      logic [31:0] val;
   } exp_t;
   exp_t q[$];
   int n_chk = 0, n_fail = 0;
   logic rd_req = 1'b0;
   logic [31:0] obs;
   rsa_mmio_ctrl #(.REG_W(8), .OP_W(16), .ADDR_W(4), .TIMEOUT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_rdata(reg_rdata), .start_pin(start_pin), .core_en(core_en), .core_rstb(core_rstb),
      .core_p(core_p), .core_e(core_e), .core_m(core_m), .core_const(core_const),
      .core_eoc(core_eoc), .core_c(core_c), .irq(irq)
   );
   always #5 clk = ~clk;
   assign obs = {core_p, 5'b0, irq, core_en, core_rstb, reg_rdata};
   // one comparison
   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
      end
   endtask
   // monitor: pops an expectation whenever a sample is presented
   always @(negedge clk) if (rd_req) begin
      exp_t e;
      if (q.size() == 0) cmp("scoreboard underflow", 32'd1, 32'd0);
      else begin
         e = q.pop_front();
         cmp(e.name, obs & e.mask, e.val & e.mask);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      reg_addr = a; reg_wdata = d; reg_we = 1'b1;
      tick();
      reg_we = 1'b0;
   endtask
   task automatic present(input logic [3:0] a, input logic [31:0] m, input logic [31:0] v, input string nm);
      q.push_back('{nm, m, v});
      reg_addr = a; rd_req = 1'b1;
      @(negedge clk);
      #1 rd_req = 1'b0;
      tick();
   endtask
   // ctl = {irq, core_en, core_rstb}
   task automatic chk(input logic [3:0] a, input logic [7:0] rd, input logic [2:0] ctl, input string nm);
      present(a, 32'h0000_07FF, {21'd0, ctl, rd}, nm);
   endtask
   task automatic chkp(input logic [15:0] p, input string nm);
      present(4'd0, 32'hFFFF_0000, {p, 16'd0}, nm);
   endtask
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int a = 0; a < 16; a++) chk(4'(a), 8'h00, 3'b000, $sformatf("reset addr%0d", a));
      chkp(16'h0000, "reset core_p");
      wr(2, 8'h34); wr(3, 8'h12); wr(4, 8'h11); wr(5, 8'h00); wr(6, 8'hAB); wr(7, 8'h00);
      chk(2, 8'h34, 3'b000, "P lo readback");
      chk(6, 8'hAB, 3'b000, "M lo readback");
      wr(1, 8'h09);
      chk(0, 8'h04, 3'b000, "LOAD status");
      chk(0, 8'h04, 3'b011, "RUN status");
      chkp(16'h1234, "snapshot P");
      repeat (17) tick();
      core_eoc = 1'b1; core_c = 16'hBEEF;
      tick();
      core_eoc = 1'b0; core_c = 16'h0000;
      chk(10, 8'hEF, 3'b101, "C lo");
      chk(11, 8'hBE, 3'b101, "C hi");
      chk(0, 8'h03, 3'b101, "DONE status");
      wr(1, 8'h0C);
      chk(0, 8'h02, 3'b001, "clr_flags status");
      chk(1, 8'h08, 3'b001, "irq_en readback");
      wr(1, 8'h09);
      tick();
      wr(2, 8'h55);
      chk(0, 8'h14, 3'b011, "write busy status");
      chkp(16'h1234, "shadow unchanged");
      chk(2, 8'h55, 3'b011, "bank updated while busy");
      wr(1, 8'h0A);
      chk(0, 8'h30, 3'b000, "stop keeps err_wr_busy");
      wr(1, 8'h0C);
      chk(0, 8'h00, 3'b000, "flags cleared");
      wr(1, 8'h09);
      n = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (core_en) n++;
         else if (n > 0) break;
      end
      tick();
      cmp("watchdog RUN cycles", 32'(n), 32'd255);
      chk(0, 8'h09, 3'b100, "timeout status");
      chkp(16'h1255, "snapshot new P");
      wr(1, 8'h04);
      chk(0, 8'h00, 3'b000, "timeout cleared");
      wr(1, 8'h01);
      tick();
      wr(1, 8'h02);
      chk(0, 8'h20, 3'b000, "abort status");
      wr(1, 8'h03);
      chk(0, 8'h20, 3'b000, "start+stop discarded");
      start_pin = 1'b1;
      tick();
      chk(0, 8'h20, 3'b000, "pin sync 1");
      chk(0, 8'h20, 3'b000, "pin sync 2");
      start_pin = 1'b0;
      chk(0, 8'h04, 3'b000, "pin LOAD");
      core_eoc = 1'b1; core_c = 16'h5A3C;
      wr(1, 8'h02);
      core_eoc = 1'b0; core_c = 16'h0000;
      chk(0, 8'h02, 3'b001, "eoc beats stop");
      chk(10, 8'h3C, 3'b001, "eoc+stop C lo");
      chk(11, 8'h5A, 3'b001, "eoc+stop C hi");
      wr(1, 8'h02);
      chk(0, 8'h02, 3'b000, "stop in DONE keeps done");
      chk(10, 8'h3C, 3'b000, "stop in DONE keeps C");
      wr(12, 8'hFF); wr(10, 8'h77); wr(0, 8'hFF);
      chk(12, 8'h00, 3'b000, "unmapped reads 0");
      chk(10, 8'h3C, 3'b000, "C not writable");
      chk(0, 8'h02, 3'b000, "STATUS not writable");
      wr(1, 8'h01);
      tick();
      #2 rst_n = 1'b0;
      chk(0, 8'h00, 3'b000, "async reset status");
      chk(2, 8'h00, 3'b000, "async reset bank");
      chkp(16'h0000, "async reset core_p");
      rst_n = 1'b1;
      chk(0, 8'h00, 3'b000, "post reset idle");
      @(negedge clk);
      if (q.size() != 0) cmp("scoreboard leftover", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
